// File: rtl/jcnt_phase_decoder.sv
// Johnson-code phase decoder: validates each sampled code against the canonical
// sequence, reports phase, tracks lock and counts revolutions while locked.
module jcnt_phase_decoder #(
    parameter int WIDTH     = 4,
    parameter int LOCK_CNT  = 3,
    parameter int ERR_LIMIT = 2,
    parameter int REV_W     = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sample_en,
    input  logic [WIDTH-1:0]              jc_in,
    output logic [2*WIDTH-1:0]            phase,
    output logic [$clog2(2*WIDTH)-1:0]    phase_idx,
    output logic                          locked,
    output logic                          code_err,
    output logic                          seq_err,
    output logic                          rev_pulse,
    output logic [REV_W-1:0]              rev_cnt
);
    localparam int N     = 2 * WIDTH;
    localparam int IDX_W = $clog2(N);
    localparam int GW    = $clog2(LOCK_CNT + 1);
    localparam int EW    = $clog2(ERR_LIMIT + 1);

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_TRACK    = 2'd1,
        ST_LOCKED   = 2'd2
    } state_t;

    // Code for index k: a run of k ones filling from the LSB, then zeros shifting in.
    function automatic logic [WIDTH-1:0] code_of(input int k);
        logic [WIDTH-1:0] ones;
        ones = '1;
        if (k <= WIDTH) code_of = ones >> (WIDTH - k);
        else            code_of = ones << (k - WIDTH);
    endfunction

    logic [N-1:0] match;
    for (genvar gi = 0; gi < N; gi++) begin : g_match
        assign match[gi] = (jc_in == code_of(gi));
    end

    state_t             state_q, state_d;
    logic [GW-1:0]      good_cnt_q, good_cnt_d;
    logic [EW-1:0]      err_cnt_q, err_cnt_d;
    logic [IDX_W-1:0]   prev_idx_q, prev_idx_d;
    logic               prev_valid_q, prev_valid_d;
    logic [N-1:0]       phase_q, phase_d;
    logic [IDX_W-1:0]   phase_idx_q, phase_idx_d;
    logic               code_err_q, code_err_d;
    logic               seq_err_q, seq_err_d;
    logic               rev_pulse_q, rev_pulse_d;
    logic [REV_W-1:0]   rev_cnt_q, rev_cnt_d;

    logic [IDX_W-1:0]   code_idx;
    logic [IDX_W-1:0]   succ_idx;
    logic               legal, stall, is_succ, prev_last;

    always_comb begin
        code_idx = '0;
        for (int k = 0; k < N; k++) begin
            if (match[k]) code_idx = k[IDX_W-1:0];
        end
    end

    assign prev_last = (prev_idx_q == IDX_W'(N - 1));
    assign succ_idx  = prev_last ? '0 : prev_idx_q + 1'b1;
    assign legal     = |match;
    assign stall     = legal && prev_valid_q && (code_idx == prev_idx_q);
    assign is_succ   = legal && prev_valid_q && (code_idx == succ_idx);

    always_comb begin
        state_d      = state_q;
        good_cnt_d   = good_cnt_q;
        err_cnt_d    = err_cnt_q;
        prev_idx_d   = prev_idx_q;
        prev_valid_d = prev_valid_q;
        phase_d      = phase_q;
        phase_idx_d  = phase_idx_q;
        rev_cnt_d    = rev_cnt_q;
        code_err_d   = 1'b0;
        seq_err_d    = 1'b0;
        rev_pulse_d  = 1'b0;

        if (sample_en) begin
            if (legal) begin
                phase_d     = match;
                phase_idx_d = code_idx;
            end else begin
                phase_d     = '0;
            end

            if (!stall) begin
                // In LOCKED a corrupt sample keeps the last good reference code.
                if (legal) begin
                    prev_idx_d   = code_idx;
                    prev_valid_d = 1'b1;
                end else if (state_q != ST_LOCKED) begin
                    prev_valid_d = 1'b0;
                end

                case (state_q)
                    ST_UNLOCKED: begin
                        if (legal) begin
                            state_d    = ST_TRACK;
                            good_cnt_d = '0;
                        end else begin
                            code_err_d = 1'b1;
                        end
                    end
                    ST_TRACK: begin
                        if (!legal) begin
                            code_err_d = 1'b1;
                            good_cnt_d = '0;
                            state_d    = ST_UNLOCKED;
                        end else if (is_succ) begin
                            good_cnt_d = good_cnt_q + 1'b1;
                            if (good_cnt_q == GW'(LOCK_CNT - 1)) begin
                                state_d   = ST_LOCKED;
                                err_cnt_d = '0;
                            end
                        end else begin
                            seq_err_d  = 1'b1;
                            good_cnt_d = '0;
                        end
                    end
                    ST_LOCKED: begin
                        if (is_succ) begin
                            err_cnt_d = '0;
                            if (prev_last) begin
                                rev_pulse_d = 1'b1;
                                rev_cnt_d   = rev_cnt_q + 1'b1;
                            end
                        end else begin
                            code_err_d = !legal;
                            seq_err_d  = legal;
                            if (err_cnt_q == EW'(ERR_LIMIT - 1)) begin
                                state_d    = ST_UNLOCKED;
                                err_cnt_d  = '0;
                                good_cnt_d = '0;
                            end else begin
                                err_cnt_d  = err_cnt_q + 1'b1;
                            end
                        end
                    end
                    default: state_d = ST_UNLOCKED;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_UNLOCKED;
            good_cnt_q   <= '0;
            err_cnt_q    <= '0;
            prev_idx_q   <= '0;
            prev_valid_q <= 1'b0;
            phase_q      <= '0;
            phase_idx_q  <= '0;
            code_err_q   <= 1'b0;
            seq_err_q    <= 1'b0;
            rev_pulse_q  <= 1'b0;
            rev_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            good_cnt_q   <= good_cnt_d;
            err_cnt_q    <= err_cnt_d;
            prev_idx_q   <= prev_idx_d;
            prev_valid_q <= prev_valid_d;
            phase_q      <= phase_d;
            phase_idx_q  <= phase_idx_d;
            code_err_q   <= code_err_d;
            seq_err_q    <= seq_err_d;
            rev_pulse_q  <= rev_pulse_d;
            rev_cnt_q    <= rev_cnt_d;
        end
    end

    assign phase     = phase_q;
    assign phase_idx = phase_idx_q;
    assign locked    = (state_q == ST_LOCKED);
    assign code_err  = code_err_q;
    assign seq_err   = seq_err_q;
    assign rev_pulse = rev_pulse_q;
    assign rev_cnt   = rev_cnt_q;

endmodule

// File: tb/tb_jcnt_phase_decoder.sv
// Directed-vector bench for jcnt_phase_decoder; a driver queues expected
// responses and a monitor compares them one cycle later.
module tb_jcnt_phase_decoder;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sample_en = 1'b0;
    logic [3:0] jc_in = 4'b0000;
    logic [7:0] phase;
    logic [2:0] phase_idx;
    logic       locked, code_err, seq_err, rev_pulse;
    logic [7:0] rev_cnt;

    jcnt_phase_decoder #(.WIDTH(4), .LOCK_CNT(3), .ERR_LIMIT(2), .REV_W(8)) dut (
        .clk(clk), .rst(rst), .sample_en(sample_en), .jc_in(jc_in),
        .phase(phase), .phase_idx(phase_idx), .locked(locked),
        .code_err(code_err), .seq_err(seq_err), .rev_pulse(rev_pulse),
        .rev_cnt(rev_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] ph;
        logic [2:0] ix;
        logic       lk, ce, se, rp;
        logic [7:0] rc;
    } exp_t;

    exp_t       exp_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         n_txn    = 0;
    int         rc_m     = 0;
    logic [3:0] codes[8] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111,
                             4'b1111, 4'b1110, 4'b1100, 4'b1000};

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL txn %0d %s: got %0h, expected %0h", n_txn, name, act, req);
        end
    endtask

    // Monitor: entries queued before an edge are checked at the following negedge.
    initial begin
        int   pend;
        exp_t e;
        forever begin
            @(posedge clk);
            pend = exp_q.size();
            @(negedge clk);
            if (pend > 0) begin
                e = exp_q.pop_front();
                n_txn++;
                $display("txn %0d: phase=%h idx=%0d locked=%b ce=%b se=%b rp=%b rev_cnt=%0d",
                         n_txn, phase, phase_idx, locked, code_err, seq_err, rev_pulse, rev_cnt);
                check("phase",     int'(phase),     int'(e.ph));
                check("phase_idx", int'(phase_idx), int'(e.ix));
                check("locked",    int'(locked),    int'(e.lk));
                check("code_err",  int'(code_err),  int'(e.ce));
                check("seq_err",   int'(seq_err),   int'(e.se));
                check("rev_pulse", int'(rev_pulse), int'(e.rp));
                check("rev_cnt",   int'(rev_cnt),   int'(e.rc));
            end
        end
    end

    task automatic step(input logic r, input logic en, input logic [3:0] jc,
                        input logic [7:0] ph, input logic [2:0] ix, input logic lk,
                        input logic ce, input logic se, input logic rp, input logic [7:0] rc);
        exp_t e;
        @(negedge clk);
        rst = r; sample_en = en; jc_in = jc;
        e.ph = ph; e.ix = ix; e.lk = lk; e.ce = ce; e.se = se; e.rp = rp; e.rc = rc;
        exp_q.push_back(e);
    endtask

    // Legal successor steps while locked; a wrap to index 0 is one revolution.
    task automatic run_locked(input int start, input int n);
        int k;
        for (int i = 1; i <= n; i++) begin
            k = (start + i) % 8;
            if (k == 0) rc_m++;
            step(0, 1, codes[k], 8'(1 << k), 3'(k), 1, 0, 0, (k == 0), 8'(rc_m));
        end
    endtask

    initial begin
        int wait_cyc;
        step(1, 0, 4'b0000, 8'h00, 0, 0, 0, 0, 0, 0);
        step(1, 0, 4'b0000, 8'h00, 0, 0, 0, 0, 0, 0);
        step(0, 1, 4'b0000, 8'h01, 0, 0, 0, 0, 0, 0);
        step(0, 1, 4'b0001, 8'h02, 1, 0, 0, 0, 0, 0);
        step(0, 1, 4'b0011, 8'h04, 2, 0, 0, 0, 0, 0);
        step(0, 1, 4'b0111, 8'h08, 3, 1, 0, 0, 0, 0);
        run_locked(3, 16);
        repeat (3) step(0, 1, 4'b0111, 8'h08, 3, 1, 0, 0, 0, 2);
        step(0, 0, 4'b1010, 8'h08, 3, 1, 0, 0, 0, 2);
        step(0, 1, 4'b0101, 8'h00, 3, 1, 1, 0, 0, 2);
        step(0, 1, 4'b0101, 8'h00, 3, 0, 1, 0, 0, 2);
        step(0, 1, 4'b0011, 8'h04, 2, 0, 0, 0, 0, 2);
        step(0, 1, 4'b1111, 8'h10, 4, 0, 0, 1, 0, 2);
        step(0, 1, 4'b1110, 8'h20, 5, 0, 0, 0, 0, 2);
        step(0, 1, 4'b1100, 8'h40, 6, 0, 0, 0, 0, 2);
        step(0, 1, 4'b1000, 8'h80, 7, 1, 0, 0, 0, 2);
        run_locked(7, 17);
        step(0, 1, 4'b0111, 8'h08, 3, 1, 0, 1, 0, 5);
        step(0, 1, 4'b1111, 8'h10, 4, 1, 0, 0, 0, 5);
        step(0, 1, 4'b0101, 8'h00, 4, 1, 1, 0, 0, 5);
        step(0, 1, 4'b1110, 8'h20, 5, 1, 0, 0, 0, 5);
        step(0, 1, 4'b0101, 8'h00, 5, 1, 1, 0, 0, 5);
        step(0, 1, 4'b1100, 8'h40, 6, 1, 0, 0, 0, 5);
        step(1, 1, 4'b0101, 8'h00, 0, 0, 0, 0, 0, 0);
        step(0, 1, 4'b1010, 8'h00, 0, 0, 1, 0, 0, 0);
        step(0, 1, 4'b0000, 8'h01, 0, 0, 0, 0, 0, 0);
        step(0, 1, 4'b0001, 8'h02, 1, 0, 0, 0, 0, 0);
        step(0, 1, 4'b1011, 8'h00, 1, 0, 1, 0, 0, 0);
        step(0, 1, 4'b0011, 8'h04, 2, 0, 0, 0, 0, 0);
        step(0, 1, 4'b0111, 8'h08, 3, 0, 0, 0, 0, 0);
        step(0, 1, 4'b1111, 8'h10, 4, 0, 0, 0, 0, 0);
        step(0, 1, 4'b1110, 8'h20, 5, 1, 0, 0, 0, 0);
        step(0, 1, 4'b0000, 8'h01, 0, 1, 0, 1, 0, 0);
        step(0, 1, 4'b1111, 8'h10, 4, 0, 0, 1, 0, 0);
        @(negedge clk);
        sample_en = 1'b0;
        wait_cyc = 0;
        while (exp_q.size() > 0 && wait_cyc < 10) begin
            @(negedge clk);
            wait_cyc++;
        end
        check("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "watchdog");
    end
endmodule
